// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: ready/valid TX engine and pulse-output RX engine.
// Define UART_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1) in both directions.

module uart_core_param #(
    parameter int unsigned CLK_DIV    = 208,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned OsW  = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = $clog2(DATA_BITS);

    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [DivW-1:0] DivOne   = DivW'(1);
    localparam logic [OsW-1:0]  OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0]  OsHalf   = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] StopLast = BitW'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic ParOdd = (PARITY_ODD != 0);
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {
        RxIdle, RxStart, RxData, RxParity, RxStop, RxWaitHigh
    } rx_state_e;

    // ---------------------------------------------------------------- TX engine
    tx_state_e            tx_state_q, tx_state_d;
    logic [DivW-1:0]      tx_div_q, tx_div_d;
    logic [OsW-1:0]       tx_os_q, tx_os_d;
    logic [BitW-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_q, tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_tick, tx_bit_end, tx_last_stop;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    assign tx_tick      = (tx_div_q == '0);
    assign tx_bit_end   = tx_tick && (tx_os_q == OsLast);
    // One cycle before the final stop tick, so a held tx_valid starts the next frame gap-free.
    assign tx_last_stop = (tx_bit_q == StopLast) && (tx_os_q == OsLast) && (tx_div_q == DivOne);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_os_d    = tx_os_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != TxIdle) begin
            tx_div_d = tx_tick ? DivLast : tx_div_q - 1'b1;
            if (tx_tick) begin
                tx_os_d = tx_os_q + 1'b1;
            end
        end
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_valid) begin
                    tx_state_d = TxStart;
                    tx_div_d   = DivLast;
                    tx_os_d    = '0;
                    tx_bit_d   = '0;
                    tx_shift_d = tx_data;
                    tx_d       = 1'b0;
`ifdef UART_PARITY_EN
                    tx_par_d   = (^tx_data) ^ ParOdd;
`endif
                end
            end
            TxStart: begin
                if (tx_bit_end) begin
                    tx_os_d    = '0;
                    tx_state_d = TxData;
                    tx_d       = tx_shift_q[0];
                end
            end
            TxData: begin
                if (tx_bit_end) begin
                    tx_os_d    = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BitLast) begin
                        tx_bit_d   = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = TxParity;
                        tx_d       = tx_par_q;
`else
                        tx_state_d = TxStop;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        tx_bit_d = tx_bit_q + 1'b1;
                        tx_d     = tx_shift_q[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            TxParity: begin
                if (tx_bit_end) begin
                    tx_os_d    = '0;
                    tx_state_d = TxStop;
                    tx_d       = 1'b1;
                end
            end
`endif
            TxStop: begin
                if (tx_last_stop) begin
                    tx_state_d = TxIdle;
                end else if (tx_bit_end) begin
                    tx_os_d  = '0;
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_d       = 1'b1;
            end
        endcase
        tx_ready_d = (tx_state_d == TxIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;
            tx_div_q   <= DivLast;
            tx_os_q    <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_os_q    <= tx_os_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;

    // ---------------------------------------------------------------- RX engine
    logic                 rx_meta_q, rx_sync_q;
    rx_state_e            rx_state_q, rx_state_d;
    logic [DivW-1:0]      rx_div_q, rx_div_d;
    logic [OsW-1:0]       rx_os_q, rx_os_d;
    logic [BitW-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_busy_q, rx_busy_d;
    logic                 rx_tick, rx_bit_end, rx_half;
`ifdef UART_PARITY_EN
    logic                 rx_par_bad_q, rx_par_bad_d;
    logic                 rx_perr_q, rx_perr_d;
`endif

    assign rx_tick    = (rx_div_q == '0);
    assign rx_bit_end = rx_tick && (rx_os_q == OsLast);
    assign rx_half    = rx_tick && (rx_os_q == OsHalf);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_os_d    = rx_os_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_bad_d = rx_par_bad_q;
        rx_perr_d    = 1'b0;
`endif
        if ((rx_state_q != RxIdle) && (rx_state_q != RxWaitHigh)) begin
            rx_div_d = rx_tick ? DivLast : rx_div_q - 1'b1;
            if (rx_tick) begin
                rx_os_d = rx_os_q + 1'b1;
            end
        end
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_div_d   = DivLast;
                    rx_os_d    = '0;
                end
            end
            RxStart: begin
                // Mid start bit: from here every full bit period lands on a bit centre.
                if (rx_half) begin
                    rx_os_d    = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_bit_end) begin
                    rx_os_d    = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BitLast) begin
                        rx_bit_d   = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = RxParity;
`else
                        rx_state_d = RxStop;
`endif
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            RxParity: begin
                if (rx_bit_end) begin
                    rx_os_d      = '0;
                    rx_par_bad_d = rx_sync_q ^ (^rx_shift_q) ^ ParOdd;
                    rx_state_d   = RxStop;
                end
            end
`endif
            RxStop: begin
                if (rx_bit_end) begin
                    if (rx_sync_q) begin
                        rx_data_d  = rx_shift_q;
                        rx_state_d = RxIdle;
`ifdef UART_PARITY_EN
                        rx_valid_d = !rx_par_bad_q;
                        rx_perr_d  = rx_par_bad_q;
`else
                        rx_valid_d = 1'b1;
`endif
                    end else begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end
                end
            end
            RxWaitHigh: begin
                if (rx_sync_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
        rx_busy_d = (rx_state_d != RxIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_div_q   <= DivLast;
            rx_os_q    <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= 1'b0;
            rx_perr_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_os_q    <= rx_os_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_busy_q  <= rx_busy_d;
`ifdef UART_PARITY_EN
            rx_par_bad_q <= rx_par_bad_d;
            rx_perr_q    <= rx_perr_d;
`endif
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_ferr_q;
    assign rx_busy      = rx_busy_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
